// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises 12-bit samples into 16-bit SPI frames for an
// MCP4921-class DAC, then pulses LDAC to update the analogue output.
// A one-deep buffer holds a sample that arrives while a frame is in flight.
//
// Handshake: update is a one-cycle strobe qualifying S. The block never
// back-pressures. While busy, a strobe is buffered. A strobe that overwrites
// an already buffered sample raises overrun in that same cycle; the latest
// sample wins.
module dac_spi_tx #(
    parameter int         CLK_DIV  = 4,
    parameter logic [3:0] CFG_BITS = 4'b0111
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] S,
    input  logic        update,
    output logic        dac_cs_n,
    output logic        dac_sclk,
    output logic        dac_mosi,
    output logic        dac_ldac_n,
    output logic        busy,
    output logic        overrun,
    output logic [1:0]  dbg_state
);

    localparam int            TW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_LDAC  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [TW-1:0]   r_tick;
    logic            r_phase;     // 0: SCLK low half, 1: SCLK high half
    logic [3:0]      r_bit;
    logic [15:0]     r_shreg;
    logic [11:0]     r_hold;
    logic            r_pending;

    logic            w_tick_end;
    logic            w_bit_done;
    logic            w_ldac_exit;
    logic            w_load;
    logic [11:0]     w_load_sample;

    assign w_tick_end    = (r_tick == TICK_MAX);
    assign w_bit_done    = (r_state == ST_SHIFT) && w_tick_end && r_phase;
    assign w_ldac_exit   = (r_state == ST_LDAC) && w_tick_end;
    // A fresh strobe takes priority over the buffered sample at LDAC exit.
    assign w_load        = ((r_state == ST_IDLE) && update) ||
                           (w_ldac_exit && (r_pending || update));
    assign w_load_sample = update ? S : r_hold;

    assign dac_cs_n   = (r_state != ST_SHIFT);
    assign dac_sclk   = (r_state == ST_SHIFT) && r_phase;
    assign dac_mosi   = r_shreg[15];
    assign dac_ldac_n = (r_state != ST_LDAC);
    assign busy       = (r_state != ST_IDLE);
    assign overrun    = update && r_pending && (r_state != ST_IDLE);
    assign dbg_state  = r_state;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: each phase ends on the last tick of the divider.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (update) w_next_state = ST_SHIFT;
            ST_SHIFT: if (w_bit_done && (r_bit == 4'd15)) w_next_state = ST_HOLD;
            ST_HOLD:  if (w_tick_end) w_next_state = ST_LDAC;
            ST_LDAC:  if (w_tick_end) w_next_state = (r_pending || update) ? ST_SHIFT : ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Divider tick, SCLK half-phase and bit counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick  <= '0;
            r_phase <= 1'b0;
            r_bit   <= 4'd0;
        end else begin
            if ((r_state == ST_IDLE) || w_tick_end) begin
                r_tick <= '0;
            end else begin
                r_tick <= r_tick + 1'b1;
            end

            if (r_state != ST_SHIFT) begin
                r_phase <= 1'b0;
                r_bit   <= 4'd0;
            end else if (w_tick_end) begin
                r_phase <= ~r_phase;
                if (r_phase) begin
                    r_bit <= r_bit + 1'b1;
                end
            end
        end
    end

    // Frame shift register: load on frame start, shift after each high phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shreg <= 16'd0;
        end else if (w_load) begin
            r_shreg <= {CFG_BITS, w_load_sample};
        end else if (w_bit_done) begin
            r_shreg <= {r_shreg[14:0], 1'b0};
        end
    end

    // One-deep sample buffer; loading a frame consumes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold    <= 12'd0;
            r_pending <= 1'b0;
        end else if (w_load) begin
            r_pending <= 1'b0;
        end else if (update && (r_state != ST_IDLE)) begin
            r_hold    <= S;
            r_pending <= 1'b1;
        end
    end

endmodule
